// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the fetch PC and reads instruction memory one word at a time over a
// req/gnt/rvalid handshake, with at most one request outstanding. Returned
// words are queued with their PCs in a small FIFO toward decode. A redirect
// loads a new PC, empties the FIFO and drops any response still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // REQ: may issue a request; WAIT: response owed to us;
    // DROP: response owed but belongs to a flushed path.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      req_pc_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic [31:0] instr_mem_q [FIFO_DEPTH];
    logic [31:0] pc_mem_q    [FIFO_DEPTH];

    logic req;
    logic push;
    logic pop;
    logic empty;

    // The request is gated by a full buffer and by a redirect in the same
    // cycle, so the address never changes under a pending request except
    // when a redirect deliberately withdraws it. Reset forces it low.
    assign empty = (count_q == '0);
    assign req   = !rst && (state_q == ST_REQ) && (count_q < DEPTH_C) && !redirect_i;
    assign push  = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;
    assign pop   = !empty && instr_ready_i && !redirect_i;

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = !empty;
    assign instr_o       = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];
    assign instr_pc_o    = empty ? 32'h0     : pc_mem_q[rd_ptr_q];

    // Fetch FSM, fetch PC and FIFO bookkeeping; redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redirect_i) begin
            fetch_pc_q <= pc_i & 32'hFFFF_FFFC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            case (state_q)
                ST_WAIT: state_q <= imem_rvalid_i ? ST_REQ : ST_DROP;
                ST_DROP: state_q <= imem_rvalid_i ? ST_REQ : ST_DROP;
                default: state_q <= ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (req && imem_gnt_i) begin
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid_i) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_REQ;
            endcase

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Buffer storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit.
// The driver plays instruction memory and decode and pushes every response
// that should reach decode into a queue; a monitor on the falling edge
// checks handshake outputs and pops the queue whenever decode takes a word.
module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect_i),
        .pc_i         (pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t sb[$];
    entry_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    // Per-cycle expectations published by the driver for the monitor.
    bit          in_reset  = 1'b1;
    bit          cyc_req   = 1'b0;
    logic [31:0] cyc_addr  = 32'h0;
    int          cyc_cnt   = 0;
    bit          cyc_redir = 1'b0;
    bit          cyc_ready = 1'b0;

    // Reference view: next fetch address and the memory's outstanding read.
    logic [31:0] exp_pc   = RST_PC;
    logic [31:0] req_addr = 32'h0;
    bit          busy     = 1'b0;
    bit          dropped  = 1'b0;
    bit          stale    = 1'b0;
    int          lat      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus/decode cycle of stimulus plus the reference bookkeeping.
    task automatic cycle(input int p_redir, input int p_ready);
        bit          redir;
        bit          rdy;
        bit          g;
        bit          r_v;
        logic [31:0] r_d;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        in_reset = 1'b0;
        cyc_cnt  = sb.size();
        redir    = (($urandom % 100) < p_redir);
        tgt      = $urandom;
        rdy      = (($urandom % 100) < p_ready);
        g        = (($urandom % 100) < 70);
        r_d      = $urandom;
        r_v      = 1'b0;
        if (stale) begin
            // Leftover response from before reset arrives while idle.
            r_v   = 1'b1;
            g     = 1'b0;
            redir = 1'b0;
            stale = 1'b0;
        end else if (busy) begin
            if (lat == 0) r_v = 1'b1;
            else          lat--;
        end
        cyc_req   = !busy && (cyc_cnt < DEPTH) && !redir;
        cyc_addr  = exp_pc;
        cyc_redir = redir;
        cyc_ready = rdy;

        redirect_i    = redir;
        pc_i          = tgt;
        instr_ready_i = rdy;
        imem_gnt_i    = g;
        imem_rvalid_i = r_v;
        imem_rdata_i  = r_d;

        if (r_v && busy) begin
            busy = 1'b0;
            if (!dropped && !redir) sb.push_back('{instr: r_d, pc: req_addr});
        end
        if (redir) begin
            sb.delete();
            exp_pc = tgt & 32'hFFFF_FFFC;
            if (busy) dropped = 1'b1;
        end else if (cyc_req && g) begin
            busy     = 1'b1;
            dropped  = 1'b0;
            req_addr = exp_pc;
            exp_pc   = exp_pc + 32'd4;
            lat      = $urandom_range(0, 3);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'h0, imem_req_o},    32'h0);
        chk({tag, "_valid"}, {31'h0, instr_valid_o}, 32'h0);
        chk({tag, "_instr"}, instr_o,                NOP);
        chk({tag, "_pc"},    instr_pc_o,             32'h0);
        chk({tag, "_addr"},  imem_addr_o,            RST_PC);
    endtask

    // Monitor: compares outputs mid-cycle and consumes the scoreboard on pops.
    always @(negedge clk) begin
        if (!in_reset) begin
            chk("imem_req", {31'h0, imem_req_o}, {31'h0, cyc_req});
            if (cyc_req) chk("imem_addr", imem_addr_o, cyc_addr);
            chk("instr_valid", {31'h0, instr_valid_o}, {31'h0, (cyc_cnt != 0)});
            if (cyc_cnt == 0) begin
                chk("empty_instr", instr_o, NOP);
                chk("empty_pc", instr_pc_o, 32'h0);
            end else if (sb.size() != 0) begin
                if (cyc_ready && !cyc_redir) begin
                    mon_e = sb.pop_front();
                    n_pop++;
                    $display("pop  pc=%h instr=%h (dut pc=%h instr=%h)",
                             mon_e.pc, mon_e.instr, instr_pc_o, instr_o);
                end else begin
                    mon_e = sb[0];
                end
                chk("head_instr", instr_o, mon_e.instr);
                chk("head_pc", instr_pc_o, mon_e.pc);
            end
        end
    end

    initial begin
        int guard;
        #2;
        check_reset_outputs("reset");
        #10 rst = 1'b0;

        for (int i = 0; i < 400; i++) cycle(5, 80);
        for (int i = 0; i < 300; i++) cycle(3, 10);
        for (int i = 0; i < 200; i++) cycle(0, 100);

        // Get a request outstanding, then assert reset between clock edges.
        guard = 0;
        while (!busy && guard < 50) begin
            cycle(0, 100);
            guard++;
        end
        chk("reach_wait", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #3;
        in_reset = 1'b1;
        rst      = 1'b1;
        stale    = busy;
        busy     = 1'b0;
        dropped  = 1'b0;
        sb.delete();
        exp_pc   = RST_PC;
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #6 rst = 1'b0;

        for (int i = 0; i < 400; i++) cycle(10, 60);
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        chk("pops_seen", {31'h0, (n_pop > 50)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
